// File: rtl/fir_pkg.sv
// Shared definitions for the FIR read-side controller: state encoding and
// default geometry of the sample RAM / coefficient ROM and MAC pipeline.
package fir_pkg;

   localparam int AW_DEF      = 5;
   localparam int SAMPLE_W    = 16;
   localparam int MAC_LAT_DEF = 2;

   typedef enum logic [2:0] {
      S_CLR,
      S_IDLE,
      S_POP,
      S_LOAD,
      S_MAC,
      S_DRAIN,
      S_OUT
   } state_t;

endpackage

// File: rtl/fir_tap_sequencer.sv
// Read-side sequencer: pops a FIFO sample into the circular sample RAM, issues
// one MAC per tap (newest sample first), waits for the MAC pipeline, then presents y_valid.
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int MAC_LAT = MAC_LAT_DEF
) (
   input  logic          clk_rd,
   input  logic          rst,
   input  logic [AW:0]   cfg_ntaps,
   input  logic          fifo_empty,
   output logic          fifo_rd_en,
   output logic          samp_we,
   output logic          samp_zero,
   output logic [AW-1:0] samp_waddr,
   output logic [AW-1:0] samp_raddr,
   output logic [AW-1:0] coef_addr,
   output logic          mac_clr,
   output logic          mac_en,
   output logic          y_valid,
   input  logic          y_ready,
   output logic          busy
);

   localparam int            DEPTH      = 1 << AW;
   localparam logic [AW-1:0] CNT_MAX    = AW'(DEPTH - 1);
   localparam logic [AW-1:0] DRAIN_LAST = AW'(MAC_LAT - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q,   cnt_d;
   logic [AW-1:0] wptr_q,  wptr_d;
   logic [AW-1:0] last_q,  last_d;
   logic          run_q,   run_d;

   // Index of the final tap after clamping the tap count into 1..DEPTH.
   function automatic logic [AW-1:0] last_tap(input logic [AW:0] ntaps);
      if (ntaps == '0)
         return '0;
      else if (ntaps > (AW+1)'(DEPTH))
         return CNT_MAX;
      else
         return AW'(ntaps - 1'b1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_rd or posedge rst) begin
      if (rst) begin
         state_q <= S_CLR;
         cnt_q   <= '0;
         wptr_q  <= '0;
         last_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         last_q  <= last_d;
         run_q   <= run_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wptr_d     = wptr_q;
      last_d     = last_q;
      run_d      = 1'b1;
      fifo_rd_en = 1'b0;
      samp_we    = 1'b0;
      samp_zero  = 1'b0;
      samp_waddr = '0;
      samp_raddr = '0;
      coef_addr  = '0;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      y_valid    = 1'b0;
      busy       = 1'b0;

      // run_q keeps every strobe low while reset is applied and for the
      // single cycle after release, so the clear sweep starts cleanly at 0.
      if (run_q) begin
         busy = (state_q != S_IDLE);
         case (state_q)
            S_CLR: begin
               samp_we    = 1'b1;
               samp_zero  = 1'b1;
               samp_waddr = cnt_q;
               if (cnt_q == CNT_MAX) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_IDLE: begin
               if (!fifo_empty) state_d = S_POP;
            end
            S_POP: begin
               if (fifo_empty) begin
                  state_d = S_IDLE;
               end else begin
                  fifo_rd_en = 1'b1;
                  last_d     = last_tap(cfg_ntaps);
                  state_d    = S_LOAD;
               end
            end
            S_LOAD: begin
               samp_we    = 1'b1;
               samp_waddr = wptr_q;
               cnt_d      = '0;
               state_d    = S_MAC;
            end
            S_MAC: begin
               mac_en     = 1'b1;
               mac_clr    = (cnt_q == '0);
               coef_addr  = cnt_q;
               samp_raddr = wptr_q - cnt_q;
               if (cnt_q == last_q) begin
                  wptr_d  = wptr_q + 1'b1;
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (cnt_q == DRAIN_LAST) begin
                  cnt_d   = '0;
                  state_d = S_OUT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_OUT: begin
               y_valid = 1'b1;
               if (y_ready) state_d = S_IDLE;
            end
            default: state_d = S_CLR;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: a FIFO model, a per-sample
// scoreboard of {write address, tap count} and a cycle monitor of the strobes.
module tb_fir_tap_sequencer;

   localparam int AW      = 5;
   localparam int MAC_LAT = 2;
   localparam int DEPTH   = 1 << AW;

   logic          clk_rd = 1'b0;
   logic          rst;
   logic [AW:0]   cfg_ntaps;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic          samp_we;
   logic          samp_zero;
   logic [AW-1:0] samp_waddr;
   logic [AW-1:0] samp_raddr;
   logic [AW-1:0] coef_addr;
   logic          mac_clr;
   logic          mac_en;
   logic          y_valid;
   logic          y_ready;
   logic          busy;

   fir_tap_sequencer #(.AW(AW), .MAC_LAT(MAC_LAT)) dut (
      .clk_rd     (clk_rd),
      .rst        (rst),
      .cfg_ntaps  (cfg_ntaps),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .samp_we    (samp_we),
      .samp_zero  (samp_zero),
      .samp_waddr (samp_waddr),
      .samp_raddr (samp_raddr),
      .coef_addr  (coef_addr),
      .mac_clr    (mac_clr),
      .mac_en     (mac_en),
      .y_valid    (y_valid),
      .y_ready    (y_ready),
      .busy       (busy)
   );

   always #5 clk_rd = ~clk_rd;

   typedef struct {
      logic [AW-1:0] waddr;
      int            n;
   } exp_t;

   typedef struct {
      int cfg;
      int exp_n;
   } vec_t;

   exp_t          sb[$];
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            pushed = 0;
   int            popped = 0;
   logic [AW-1:0] wptr_m = '0;

   assign fifo_empty = (pushed == popped);

   always @(posedge clk_rd) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) popped <= popped + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: checks every strobe against the addressing rules and retires
   // scoreboard entries when an output is accepted.
   int            clr_addr = 0;
   int            k = 0;
   int            last_mac_cyc = 0;
   logic [AW-1:0] cur_waddr = '0;
   bit            yv_prev = 0;
   bit            acc_prev = 0;

   always @(negedge clk_rd) begin
      if (rst) begin
         clr_addr = 0;
         k        = 0;
         yv_prev  = 0;
         acc_prev = 0;
      end else begin
         if (samp_we && samp_zero) begin
            check("clr_addr", samp_waddr, clr_addr);
            clr_addr++;
         end
         if (samp_we && !samp_zero) begin
            cur_waddr = samp_waddr;
            k = 0;
         end
         if (fifo_rd_en) check("pop_nonempty", fifo_empty, 0);
         if (mac_clr) check("mac_clr_with_en", mac_en, 1);
         if (mac_en) begin
            check("coef_addr", coef_addr, k);
            check("samp_raddr", samp_raddr, AW'(cur_waddr - AW'(k)));
            check("mac_clr", mac_clr, (k == 0));
            k++;
            last_mac_cyc = cyc;
         end
         if (acc_prev) check("y_valid_drop", y_valid, 0);
         if (y_valid && !yv_prev) check("y_latency", cyc - last_mac_cyc, MAC_LAT + 1);
         if (y_valid && y_ready) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("waddr", cur_waddr, e.waddr);
               check("ntaps", k, e.n);
            end
         end
         acc_prev = y_valid && y_ready;
         yv_prev  = y_valid;
      end
   end

   task automatic send(input int cfg, input int exp_n);
      exp_t e;
      cfg_ntaps = (AW+1)'(cfg);
      e.waddr = wptr_m;
      e.n     = exp_n;
      sb.push_back(e);
      wptr_m++;
      pushed++;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      @(negedge clk_rd);
      while ((busy || sb.size() != 0 || pushed != popped) && n < budget) begin
         @(negedge clk_rd);
         n++;
      end
      check({name, "_timeout"}, (n < budget), 1);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {fifo_rd_en, samp_we, samp_zero, samp_waddr, samp_raddr, coef_addr,
                   mac_clr, mac_en, y_valid, busy}, 0);
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{cfg: 0,  exp_n: 1};
      vecs[1] = '{cfg: 1,  exp_n: 1};
      vecs[2] = '{cfg: 4,  exp_n: 4};
      vecs[3] = '{cfg: 7,  exp_n: 7};
      vecs[4] = '{cfg: 31, exp_n: 31};
      vecs[5] = '{cfg: 32, exp_n: 32};
      vecs[6] = '{cfg: 33, exp_n: 32};
      vecs[7] = '{cfg: 40, exp_n: 32};
      vecs[8] = '{cfg: 63, exp_n: 32};

      rst       = 1'b1;
      cfg_ntaps = 6'd4;
      y_ready   = 1'b1;
      repeat (3) @(negedge clk_rd);
      check_outputs_zero("reset_outputs");

      // Post-reset clear sweep with the FIFO empty.
      rst = 1'b0;
      wait_idle("clr", 100);
      check("clr_count", clr_addr, DEPTH);
      check("busy_after_clr", busy, 0);

      // Single sample, four taps.
      send(4, 4);
      wait_idle("single", 200);
      check("single_pops", popped, 1);

      for (int i = 0; i < 9; i++) begin
         send(vecs[i].cfg, vecs[i].exp_n);
         wait_idle($sformatf("vec%0d", i), 200);
      end

      // Back-to-back samples wrap the write pointer.
      for (int i = 0; i < 33; i++) send(4, 4);
      wait_idle("wrap", 33 * 20);

      // Output stall with more data waiting in the FIFO.
      begin
         int n = 0;
         int p0;
         y_ready = 1'b0;
         send(4, 4);
         send(4, 4);
         while (!y_valid && n < 100) begin
            @(negedge clk_rd);
            n++;
         end
         check("stall_y_valid_timeout", (n < 100), 1);
         p0 = popped;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk_rd);
            check("stall_y_valid_held", y_valid, 1);
            check("stall_no_pop", fifo_rd_en, 0);
         end
         check("stall_pop_count", popped, p0);
         y_ready = 1'b1;
         wait_idle("stall", 200);
      end

      // Tap count changed mid-burst must not alter the burst in flight.
      begin
         int n = 0;
         send(8, 8);
         while (!mac_en && n < 100) begin
            @(negedge clk_rd);
            n++;
         end
         check("midcfg_mac_timeout", (n < 100), 1);
         cfg_ntaps = 6'd2;
         wait_idle("midcfg", 200);
         send(2, 2);
         wait_idle("midcfg_next", 200);
      end

      // Reset in the middle of a MAC burst.
      begin
         int n = 0;
         send(8, 8);
         while (!(mac_en && coef_addr == 5'd2) && n < 100) begin
            @(negedge clk_rd);
            n++;
         end
         check("abort_mac_timeout", (n < 100), 1);
         rst = 1'b1;
         #1;
         check_outputs_zero("abort_outputs");
         sb.delete();
         wptr_m = '0;
         repeat (2) @(negedge clk_rd);
         rst = 1'b0;
         wait_idle("abort_clr", 100);
         check("abort_clr_count", clr_addr, DEPTH);
         send(4, 4);
         wait_idle("after_abort", 200);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
